// File: rtl/mmio_console.sv
// mmio_console: memory-mapped console and halt device on the data-memory bus.
// TXDATA stores feed a TX FIFO drained over a valid/ready byte stream; an EXIT
// store halts the run with an exit code; a free-running cycle counter is readable.
module mmio_console #(
    parameter logic [31:0] ADDR_BASE  = 32'hFFFF_0000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    input  logic        mem_re,
    output logic        sel,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halt,
    output logic [31:0] exit_code,
    output logic        done
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_EXIT   = 2'd2;
    localparam logic [1:0] OFF_CYCLE  = 2'd3;

    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        r_overflow;
    logic        r_halt;
    logic [31:0] r_exit_code;
    logic [31:0] r_cycle;

    logic [1:0]  w_off;
    logic        w_wr;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_push_req;
    logic        w_push;
    logic        w_exit_wr;
    logic        w_unused_addr;

    assign sel        = (mem_addr[31:4] == ADDR_BASE[31:4]);
    assign w_off      = mem_addr[3:2];
    assign w_wr       = sel & mem_we;
    assign w_unused_addr = ^mem_addr[1:0];

    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = ((r_wptr ^ r_rptr) == {1'b1, {AW{1'b0}}});
    assign w_pop      = tx_valid & tx_ready;
    assign w_push_req = w_wr & (w_off == OFF_TXDATA) & ~r_halt;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_exit_wr  = w_wr & (w_off == OFF_EXIT) & ~r_halt;

    assign tx_valid   = ~w_empty;
    // Head byte is forced to zero when empty so the reset value is defined without clearing storage.
    assign tx_data    = w_empty ? 8'h00 : r_mem[r_rptr[AW-1:0]];
    assign halt       = r_halt;
    assign exit_code  = r_exit_code;
    assign done       = r_halt & w_empty;

    // FIFO storage: written on accepted pushes, no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= mem_wdata[7:0];
        end
    end

    // FIFO pointers and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push_req && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else if (w_wr && (w_off == OFF_STATUS) && mem_wdata[1]) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Halt latch: first EXIT write wins and holds until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halt      <= 1'b0;
            r_exit_code <= '0;
        end else if (w_exit_wr) begin
            r_halt      <= 1'b1;
            r_exit_code <= mem_wdata;
        end
    end

    // Cycle counter: runs until halted, holding its value from the halting edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle <= '0;
        end else if (!r_halt && !w_exit_wr) begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    // Combinational load path, zero when not selected for a read.
    always_comb begin
        rdata = '0;
        if (sel && mem_re) begin
            case (w_off)
                OFF_TXDATA: rdata = '0;
                OFF_STATUS: rdata = {28'b0, r_halt, r_overflow, w_full, w_empty};
                OFF_EXIT:   rdata = r_exit_code;
                OFF_CYCLE:  rdata = r_cycle;
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_console.sv
// Directed self-checking bench for mmio_console.
module tb_mmio_console;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic        sel;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halt;
    logic [31:0] exit_code;
    logic        done;

    int errors = 0;
    int checks = 0;

    mmio_console #(
        .ADDR_BASE (BASE),
        .FIFO_DEPTH(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_re   (mem_re),
        .sel      (sel),
        .rdata    (rdata),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .halt     (halt),
        .exit_code(exit_code),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_we = 1'b0;
        mem_re = 1'b0;
        tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        mem_addr  = addr;
        mem_wdata = data;
        mem_we    = 1'b1;
        @(negedge clk);
        mem_we    = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data);
        mem_addr = addr;
        mem_re   = 1'b1;
        #1;
        data     = rdata;
        mem_re   = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b1; mem_addr = '0; mem_wdata = '0; mem_we = 1'b0; mem_re = 1'b0; tx_ready = 1'b0;
        #11;
        rst = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt got=%b exp=0", halt); end
        checks++; if (exit_code !== 32'h0) begin errors++; $display("FAIL reset_exit_code got=%h exp=0", exit_code); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        do_read(BASE + 32'h4, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL reset_status got=%h exp=1", v); end
        checks++; if (sel !== 1'b1) begin errors++; $display("FAIL sel_hit got=%b exp=1", sel); end
        do_read(BASE + 32'hC, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_cycle got=%h exp=0", v); end
        mem_addr = 32'hFFFF_0014;
        #1;
        checks++; if (sel !== 1'b0) begin errors++; $display("FAIL sel_miss got=%b exp=0", sel); end
        mem_addr = BASE + 32'h4;
        #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rdata_no_re got=%h exp=0", rdata); end
    endtask

    task automatic test_bytes();
        apply_reset();
        do_write(32'hFFFF_0010, 32'h77);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL unselected_write got=%b exp=0", tx_valid); end
        do_write(BASE, 32'h48);
        do_write(BASE + 32'h1, 32'h69);
        repeat (3) @(negedge clk);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h48) begin errors++; $display("FAIL hold_first got=%b/%h exp=1/48", tx_valid, tx_data); end
        tx_ready = 1'b1;
        #1;
        checks++; if (tx_data !== 8'h48) begin errors++; $display("FAIL drain_first got=%h exp=48", tx_data); end
        @(negedge clk);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h69) begin errors++; $display("FAIL drain_second got=%b/%h exp=1/69", tx_valid, tx_data); end
        @(negedge clk);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        apply_reset();
        for (int i = 1; i <= 9; i++) do_write(BASE, i);
        do_read(BASE + 32'h4, v);
        checks++; if (v !== 32'h6) begin errors++; $display("FAIL ovf_status got=%h exp=6", v); end
        do_write(BASE + 32'h4, 32'h2);
        do_read(BASE + 32'h4, v);
        checks++; if (v !== 32'h2) begin errors++; $display("FAIL ovf_clear got=%h exp=2", v); end
        @(negedge clk);
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            #1;
            checks++; if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin errors++; $display("FAIL ovf_drain_%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, 8'(i)); end
            @(negedge clk);
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain_end got=%b exp=0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [31:0] v;
        logic [7:0]  exp_q[$];
        apply_reset();
        for (int i = 0; i < 8; i++) do_write(BASE, 32'h10 + i);
        @(negedge clk);
        tx_ready = 1'b1; mem_addr = BASE; mem_wdata = 32'h55; mem_we = 1'b1;
        #1;
        checks++; if (tx_data !== 8'h10) begin errors++; $display("FAIL fpp_head got=%h exp=10", tx_data); end
        @(negedge clk);
        mem_we = 1'b0; tx_ready = 1'b0;
        do_read(BASE + 32'h4, v);
        checks++; if (v !== 32'h2) begin errors++; $display("FAIL fpp_status got=%h exp=2", v); end
        for (int i = 1; i < 8; i++) exp_q.push_back(8'(8'h10 + i));
        exp_q.push_back(8'h55);
        @(negedge clk);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (tx_valid !== 1'b1 || tx_data !== exp_q[i]) begin errors++; $display("FAIL fpp_drain_%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp_q[i]); end
            @(negedge clk);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'h30 + i - 1)) begin errors++; $display("FAIL b2b_%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, 8'(8'h30 + i - 1)); end
            end
            mem_addr = BASE; mem_wdata = 32'h30 + i; mem_we = 1'b1;
        end
        @(negedge clk);
        mem_we = 1'b0;
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h33) begin errors++; $display("FAIL b2b_last got=%b/%h exp=1/33", tx_valid, tx_data); end
        @(negedge clk);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%b exp=0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_cycle();
        logic [31:0] v;
        apply_reset();
        repeat (5) @(negedge clk);
        do_read(BASE + 32'hC, v);
        checks++; if (v !== 32'd5) begin errors++; $display("FAIL cycle_5 got=%0d exp=5", v); end
        repeat (15) @(negedge clk);
        do_read(BASE + 32'hC, v);
        checks++; if (v !== 32'd20) begin errors++; $display("FAIL cycle_20 got=%0d exp=20", v); end
    endtask

    task automatic test_halt();
        logic [31:0] v;
        logic [31:0] c0;
        apply_reset();
        do_write(BASE, 32'hA1);
        do_write(BASE, 32'hA2);
        do_write(BASE, 32'hA3);
        do_write(BASE + 32'h8, 32'h2A);
        checks++; if (halt !== 1'b1 || exit_code !== 32'd42) begin errors++; $display("FAIL halt_set got=%b/%0d exp=1/42", halt, exit_code); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL halt_done_early got=%b exp=0", done); end
        do_write(BASE + 32'h8, 32'h7);
        checks++; if (exit_code !== 32'd42) begin errors++; $display("FAIL exit_sticky got=%0d exp=42", exit_code); end
        do_read(BASE + 32'h8, v);
        checks++; if (v !== 32'd42) begin errors++; $display("FAIL exit_read got=%0d exp=42", v); end
        do_write(BASE, 32'hEE);
        do_read(BASE + 32'h4, v);
        checks++; if (v !== 32'h8) begin errors++; $display("FAIL halt_status got=%h exp=8", v); end
        do_read(BASE + 32'hC, c0);
        repeat (10) @(negedge clk);
        do_read(BASE + 32'hC, v);
        checks++; if (v !== c0) begin errors++; $display("FAIL cycle_frozen got=%0d exp=%0d", v, c0); end
        @(negedge clk);
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'hA1 + i) || done !== 1'b0) begin errors++; $display("FAIL halt_drain_%0d got=%b/%h/done%b exp=1/%h/done0", i, tx_valid, tx_data, done, 8'(8'hA1 + i)); end
            @(negedge clk);
        end
        checks++; if (done !== 1'b1 || tx_valid !== 1'b0) begin errors++; $display("FAIL halt_done got=%b/%b exp=1/0", done, tx_valid); end
        tx_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bytes();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_cycle();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmio_console.md
# mmio_console

Memory-mapped console and halt device on the MIPS data-memory bus. It is the return path from the CPU to the simulation bench. Program stores to its window push characters into a FIFO that drains over a valid/ready byte stream, and a store to the EXIT register halts the run with an exit code. A free-running cycle counter is readable so programs can time themselves. It sits beside `data_memory`, decoded in parallel on the same address, write-data and enable signals.

## Interface

Parameters:
- `ADDR_BASE`, default 32'hFFFF_0000: base of the 16-byte register window. Bits [3:0] must be zero.
- `FIFO_DEPTH`, default 8: TX FIFO entries. Must be a power of 2 and at least 2.

Ports:
- `clk`, in, 1: the single clock. Everything is sampled on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `mem_addr`, in, 32: data address from the CPU.
- `mem_wdata`, in, 32: store data.
- `mem_we`, in, 1: store strobe, sampled at the rising edge.
- `mem_re`, in, 1: load strobe, combinational.
- `sel`, out, 1: address hits the window. The CPU uses it to mux `rdata` over `data_memory`.
- `rdata`, out, 32: load data. Combinational.
- `tx_data`, out, 8: byte at the FIFO head.
- `tx_valid`, out, 1: FIFO is not empty.
- `tx_ready`, in, 1: sink accepts the byte.
- `halt`, out, 1: EXIT has been written. Sticky.
- `exit_code`, out, 32: value latched by the EXIT write.
- `done`, out, 1: `halt` is set and `tx_valid` is low. The bench ends the simulation on this.

## Operation

Address decode:
- `sel` = (`mem_addr`[31:4] == `ADDR_BASE`[31:4]).
- Register offset = `mem_addr`[3:2]. Bits [1:0] are ignored.
- `mem_we` and `mem_re` are ignored when `sel` is 0.

Registers:
- 0x0 TXDATA
  - Write: push `mem_wdata`[7:0].
  - Read: returns 0.
- 0x4 STATUS
  - Read: {28'b0, halt, overflow, full, empty}.
  - Write: if `mem_wdata`[1] is 1, clear overflow. Other bits are ignored.
- 0x8 EXIT
  - Write: set `halt` and latch `exit_code` = `mem_wdata`.
  - Read: returns `exit_code`.
- 0xC CYCLE
  - Read: 32-bit cycle counter.
  - Write: ignored.

Read data:
- `rdata` = register value when `sel` and `mem_re` are both 1; otherwise 0.

FIFO rules:
- Circular buffer with read/write pointers one bit wider than log2(`FIFO_DEPTH`).
- Full: pointers differ only in the MSB. Empty: pointers are equal.
- Push happens when a TXDATA write occurs and `halt` is 0.
- Push while full (with no pop in the same cycle): the byte is dropped and overflow is set (sticky).
- Pop happens when `tx_valid` and `tx_ready` are both 1.
- Push and pop in the same cycle while full: both are accepted, occupancy is unchanged, and overflow is not set.
- Pop while empty: impossible, because `tx_valid` is 0.
- Pointers wrap modulo 2×`FIFO_DEPTH`.

Halt rules:
- The first EXIT write wins. Later EXIT writes are ignored until reset.
- After `halt`:
  - TXDATA writes are dropped and do not set overflow.
  - The FIFO keeps draining.
  - The STATUS overflow-clear write still works.

Cycle counter:
- Increments by 1 every clock while `halt` is 0.
- Wraps from 32'hFFFF_FFFF to 0.
- Freezes at the value it holds on the edge that sets `halt`.
- A same-cycle read returns the value before that edge's increment.

## Timing

Reset values (while `rst` is high, asynchronously):
- FIFO pointers 0.
- `tx_valid` 0.
- `tx_data` 8'h00.
- overflow 0.
- `halt` 0.
- `exit_code` 0.
- Cycle counter 0.
- `done` 0.
- `sel` and `rdata` stay combinational on the bus inputs.

Reset asserted mid-operation:
- Discards all FIFO contents immediately.
- Any in-flight handshake is lost.

Latencies:
- Push: a TXDATA write sampled at edge N makes `tx_valid` 1 and `tx_data` equal to the byte after edge N, with no bubble when the FIFO was empty.
- Pop: the handshake at edge N advances the head after edge N.
- `tx_data` is stable while `tx_valid` is 1 and `tx_ready` is 0.
- Sustained throughput is one byte per clock in and one byte per clock out.
- EXIT write sampled at edge N: `halt` is 1 after edge N.
- `done` goes to 1 in the same cycle that `halt` is 1 and the FIFO is empty.
- Loads: combinational, zero-cycle, matching the single-cycle `data_memory` read path.

## Test plan

- **Reset:** hold `rst` for 11 ns, then release.
  - Every output is at its reset value.
  - A load from 0xFFFF_0004 returns 32'h1 (empty).
- **Bytes in, then drain:** `tx_ready`=0; store 'H' (0x48) then 'i' (0x69) to 0xFFFF_0000; then raise `tx_ready`.
  - 0x48 stays held while `tx_ready` is low.
  - With `tx_ready` high, 0x48 and then 0x69 appear on consecutive cycles.
  - `tx_valid` drops after the second byte.
- **Overflow:** `tx_ready`=0; do 9 TXDATA stores with `FIFO_DEPTH`=8.
  - STATUS reads 32'h6 (full, overflow).
  - Writing 32'h2 to STATUS brings the read back to 32'h2 (full only).
  - Draining returns exactly bytes 1–8.
- **Full with simultaneous push/pop:** with the FIFO full and `tx_ready`=1, store one byte.
  - Overflow stays 0.
  - The new byte emerges 8th in order.
- **Halt:** store 32'h2A to 0xFFFF_0008 with 3 bytes queued and `tx_ready` low.
  - `halt`=1 and `exit_code`=42.
  - A later EXIT write of 7 leaves 42.
  - Later TXDATA stores are dropped.
  - `done` rises only after the 3 queued bytes drain.
- **Cycle counter:** read 0xFFFF_000C at cycle 5 after reset, then again at cycle 20.
  - Returns 5, then 20.
  - After `halt`, two reads 10 cycles apart return equal values.
